// File: rtl/tpu_run_sequencer.sv
// Run controller for the TPU datapath: pops one weight tile, pulses the weight reload,
// streams unified-buffer read addresses and writes delayed result rows to the result SRAM.
module tpu_run_sequencer #(
    parameter int ADDRESSSIZE = 10,
    parameter int RES_LAT     = 17,
    parameter int LEN_BW      = 11
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDRESSSIZE-1:0] cfg_src_base,
    input  logic [ADDRESSSIZE-1:0] cfg_dst_base,
    input  logic [LEN_BW-1:0]      cfg_len,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    output logic                   we_rl,
    output logic [ADDRESSSIZE-1:0] ub_addr,
    output logic                   ub_rd_valid,
    output logic                   res_we,
    output logic [ADDRESSSIZE-1:0] res_addr,
    output logic                   busy,
    output logic                   end_,
    output logic                   err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WLOAD  = 3'd1,
        ST_WRL    = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [ADDRESSSIZE-1:0] src_base_r;
    logic [ADDRESSSIZE-1:0] dst_base_r;
    logic [ADDRESSSIZE-1:0] ub_addr_r;
    logic [LEN_BW-1:0]      len_r;
    logic [LEN_BW-1:0]      issue_cnt_r;
    logic [LEN_BW-1:0]      wr_cnt_r;
    logic [RES_LAT-1:0]     valid_sr_r;
    logic                   last_issue_s;
    logic                   last_write_s;

    assign last_issue_s = (issue_cnt_r == (len_r - LEN_BW'(1)));
    assign last_write_s = res_we && ((wr_cnt_r + LEN_BW'(1)) == len_r);

    // Abort suppresses every strobe in the cycle it is seen, so nothing leaks past it.
    assign res_we   = valid_sr_r[RES_LAT-1] && !abort;
    assign res_addr = dst_base_r + wr_cnt_r[ADDRESSSIZE-1:0];
    assign ub_addr  = ub_addr_r;
    assign busy     = (state_r != ST_IDLE);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; abort overrides every transition
    always_comb begin
        state_next_s = state_r;
        if (abort) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_next_s = (cfg_len == LEN_BW'(0)) ? ST_DONE : ST_WLOAD;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_WLOAD: begin
                    if (!fifo_empty) begin
                        state_next_s = ST_WRL;
                    end else begin
                        state_next_s = ST_WLOAD;
                    end
                end
                ST_WRL:    state_next_s = ST_STREAM;
                ST_STREAM: begin
                    if (last_issue_s) begin
                        state_next_s = ST_DRAIN;
                    end else begin
                        state_next_s = ST_STREAM;
                    end
                end
                ST_DRAIN: begin
                    if (last_write_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_DRAIN;
                    end
                end
                ST_DONE:   state_next_s = ST_IDLE;
                default:   state_next_s = ST_IDLE;
            endcase
        end
    end

    // Strobe outputs decoded from the current state
    always_comb begin
        fifo_read_enable = 1'b0;
        we_rl            = 1'b0;
        ub_rd_valid      = 1'b0;
        end_             = 1'b0;
        err              = 1'b0;
        if (!abort) begin
            case (state_r)
                ST_WLOAD:  fifo_read_enable = !fifo_empty;
                ST_WRL:    we_rl = 1'b1;
                ST_STREAM: ub_rd_valid = 1'b1;
                ST_DONE: begin
                    end_ = 1'b1;
                    err  = (len_r == LEN_BW'(0));
                end
                default: begin
                    fifo_read_enable = 1'b0;
                end
            endcase
        end else begin
            fifo_read_enable = 1'b0;
        end
    end

    // Run configuration, address/issue/write counters and the result-valid delay line
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            src_base_r  <= '0;
            dst_base_r  <= '0;
            len_r       <= '0;
            ub_addr_r   <= '0;
            issue_cnt_r <= '0;
            wr_cnt_r    <= '0;
            valid_sr_r  <= '0;
        end else if (abort) begin
            issue_cnt_r <= '0;
            wr_cnt_r    <= '0;
            valid_sr_r  <= '0;
        end else begin
            valid_sr_r <= {valid_sr_r[RES_LAT-2:0], ub_rd_valid};
            if ((state_r == ST_IDLE) && start) begin
                src_base_r  <= cfg_src_base;
                dst_base_r  <= cfg_dst_base;
                len_r       <= cfg_len;
                issue_cnt_r <= '0;
                wr_cnt_r    <= '0;
            end else if (state_r == ST_WRL) begin
                ub_addr_r <= src_base_r;
            end else if (ub_rd_valid) begin
                issue_cnt_r <= issue_cnt_r + LEN_BW'(1);
                // The final address stays on ub_addr once streaming stops.
                if (!last_issue_s) begin
                    ub_addr_r <= ub_addr_r + ADDRESSSIZE'(1);
                end
            end
            if (res_we) begin
                wr_cnt_r <= wr_cnt_r + LEN_BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_tpu_run_sequencer.sv
// Randomized and directed bench for tpu_run_sequencer; expected strobes come from a
// timeline model derived from the run latency rules.
module tb_tpu_run_sequencer;

    localparam int AW      = 10;
    localparam int RES_LAT = 17;
    localparam int LBW     = 11;

    logic            clk;
    logic            rstn;
    logic            start;
    logic            abort;
    logic [AW-1:0]   cfg_src_base;
    logic [AW-1:0]   cfg_dst_base;
    logic [LBW-1:0]  cfg_len;
    logic            fifo_empty;
    logic            fifo_read_enable;
    logic            we_rl;
    logic [AW-1:0]   ub_addr;
    logic            ub_rd_valid;
    logic            res_we;
    logic [AW-1:0]   res_addr;
    logic            busy;
    logic            end_;
    logic            err;

    int tests;
    int fails;

    tpu_run_sequencer #(.ADDRESSSIZE(AW), .RES_LAT(RES_LAT), .LEN_BW(LBW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base), .cfg_len(cfg_len),
        .fifo_empty(fifo_empty), .fifo_read_enable(fifo_read_enable), .we_rl(we_rl),
        .ub_addr(ub_addr), .ub_rd_valid(ub_rd_valid), .res_we(res_we), .res_addr(res_addr),
        .busy(busy), .end_(end_), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_pop"}, 0, {31'd0, fifo_read_enable}, 32'd0);
        chk({tag, "_we_rl"}, 0, {31'd0, we_rl}, 32'd0);
        chk({tag, "_ub_valid"}, 0, {31'd0, ub_rd_valid}, 32'd0);
        chk({tag, "_ub_addr"}, 0, {22'd0, ub_addr}, 32'd0);
        chk({tag, "_res_we"}, 0, {31'd0, res_we}, 32'd0);
        chk({tag, "_res_addr"}, 0, {22'd0, res_addr}, 32'd0);
        chk({tag, "_busy"}, 0, {31'd0, busy}, 32'd0);
        chk({tag, "_end"}, 0, {31'd0, end_}, 32'd0);
        chk({tag, "_err"}, 0, {31'd0, err}, 32'd0);
    endtask

    // One run: start at cycle 0; FIFO empty for cycles 1..d; optional abort cycle,
    // truncation after max_c cycles, and a second start request at cycle 5.
    task automatic run_case(input int src, input int dst, input int len, input int d,
                            input int abort_c, input int max_c, input bit busy_start);
        int  e_end;
        int  total;
        bit  live;
        bit  e_pop, e_rl, e_val, e_wr, e_busy, e_done, e_err;
        e_end = (len == 0) ? 1 : (3 + d + RES_LAT + len);
        total = (abort_c >= 0) ? (abort_c + 2) : (e_end + 2);
        if (max_c >= 0 && max_c < total) total = max_c;
        for (int c = 0; c < total; c++) begin
            live  = (abort_c < 0) || (c < abort_c);
            start = (c == 0) || (busy_start && c == 5);
            abort = (c == abort_c);
            if (c == 0) begin
                cfg_src_base = AW'(src);
                cfg_dst_base = AW'(dst);
                cfg_len      = LBW'(len);
            end else begin
                cfg_src_base = AW'($urandom);
                cfg_dst_base = AW'($urandom);
                cfg_len      = LBW'($urandom);
            end
            if (c >= 1 && c <= d) fifo_empty = 1'b1;
            else if (c == 1 + d)  fifo_empty = 1'b0;
            else                  fifo_empty = 1'($urandom);
            e_pop  = live && len != 0 && c == 1 + d;
            e_rl   = live && len != 0 && c == 2 + d;
            e_val  = live && len != 0 && c >= 3 + d && c <= 2 + d + len;
            e_wr   = live && len != 0 && c >= 3 + d + RES_LAT && c <= 2 + d + RES_LAT + len;
            e_done = live && c == e_end;
            e_err  = live && len == 0 && c == 1;
            e_busy = c >= 1 && c <= e_end && (abort_c < 0 || c <= abort_c);
            @(negedge clk);
            chk("pop", c, {31'd0, fifo_read_enable}, {31'd0, e_pop});
            chk("we_rl", c, {31'd0, we_rl}, {31'd0, e_rl});
            chk("ub_valid", c, {31'd0, ub_rd_valid}, {31'd0, e_val});
            if (e_val) chk("ub_addr", c, {22'd0, ub_addr}, 32'((src + c - 3 - d) % 1024));
            chk("res_we", c, {31'd0, res_we}, {31'd0, e_wr});
            if (e_wr) chk("res_addr", c, {22'd0, res_addr}, 32'((dst + c - 3 - d - RES_LAT) % 1024));
            chk("busy", c, {31'd0, busy}, {31'd0, e_busy});
            chk("end", c, {31'd0, end_}, {31'd0, e_done});
            chk("err", c, {31'd0, err}, {31'd0, e_err});
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int len_r;
        tests = 0;
        fails = 0;
        rstn = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg_src_base = '0;
        cfg_dst_base = '0;
        cfg_len = '0;
        fifo_empty = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Basic run, long FIFO stall with an ignored start, address wrap, empty run
        run_case(0, 'h100, 4, 0, -1, -1, 1'b0);
        run_case(5, 7, 3, 10, -1, -1, 1'b1);
        run_case(1022, 1023, 3, 0, -1, -1, 1'b0);
        run_case(12, 34, 0, 0, -1, -1, 1'b0);

        // Abort in DRAIN after two of four writes; abort together with start in IDLE
        run_case(0, 'h100, 4, 0, 3 + RES_LAT + 2, -1, 1'b0);
        run_case(50, 60, 4, 0, 0, -1, 1'b0);
        run_case(70, 80, 4, 2, 5, -1, 1'b0);

        // Asynchronous reset in the middle of streaming, then a clean run
        run_case(10, 20, 8, 0, -1, 6, 1'b0);
        rstn = 1'b0;
        #1;
        chk_idle_outputs("mid_reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        run_case(900, 1000, 6, 1, -1, -1, 1'b0);

        // Randomized runs
        for (int k = 0; k < 8; k++) begin
            len_r = 1 + int'($urandom_range(39, 0));
            run_case(int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)), len_r,
                     int'($urandom_range(4, 0)), -1, -1, 1'($urandom));
        end

        // Full-size run
        run_case(int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)), 1024, 0, -1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
